irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/isa_pkg.sv | 14 +
 rtl/irq_controller_if.sv | 35 +++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_controller.sv | 103 ++++++++++
 tb/tb_irq_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the interrupt subsystem.
//   irq_state_t     : controller FSM states (IDLE, REQ, SERVICE)
//   IRQ_VECTOR_BASE : base address of the interrupt vector table
package isa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] IRQ_VECTOR_BASE = 8'h80;

endpackage

// File: rtl/irq_controller_if.sv
// Bus between the interrupt controller and the CPU / mask-programming side.
//   irq_src    : raw interrupt lines, rising-edge significant
//   mask_we    : enable-mask write strobe
//   mask_wdata : new enable mask (1 = enabled)
//   int_req    : interrupt request to the CPU
//   int_ack    : CPU acknowledge
//   int_done   : one-cycle pulse on RETI completion
//   int_id     : index of the source being requested or serviced
//   pending    : pending register
//   mask       : enable mask register
// master = CPU side, slave = controller side.
interface irq_controller_if #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_W        = $clog2(NUM_SOURCES)
);
    logic [NUM_SOURCES-1:0] irq_src;
    logic                   mask_we;
    logic [NUM_SOURCES-1:0] mask_wdata;
    logic                   int_req;
    logic                   int_ack;
    logic                   int_done;
    logic [ID_W-1:0]        int_id;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] mask;

    modport master (
        output irq_src, mask_we, mask_wdata, int_ack, int_done,
        input  int_req, int_id, pending, mask
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, int_ack, int_done,
        output int_req, int_id, pending, mask
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   vec   : request vector
//   valid : at least one bit of vec is set
//   idx   : index of the lowest set bit (0 when vec is empty)
module irq_prio_enc #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_W        = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] vec,
    output logic                   valid,
    output logic [ID_W-1:0]        idx
);

    always_comb begin
        // NOTE: every output gets a default before any conditional
        // assignment so no latch can be inferred.
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge detection on the source lines, a pending
// register, an enable mask, and a three-state IDLE/REQ/SERVICE handshake with
// the CPU. Lowest pending-and-enabled index wins; no nesting.
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high reset
//   bus   : controller side of irq_controller_if (see that file)
module irq_controller
    import isa_pkg::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int ID_W        = $clog2(NUM_SOURCES)
) (
    input  logic                clk,
    input  logic                reset,
    irq_controller_if.slave     bus
);

    logic [NUM_SOURCES-1:0] prev;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] clear;
    logic [NUM_SOURCES-1:0] pending_next;
    irq_state_t             state;
    irq_state_t             state_next;
    logic [ID_W-1:0]        int_id;
    logic                   int_req;
    logic                   enc_valid;
    logic [ID_W-1:0]        enc_idx;

    assign rise = bus.irq_src & ~prev;

    irq_prio_enc #(
        .NUM_SOURCES (NUM_SOURCES),
        .ID_W        (ID_W)
    ) u_prio_enc (
        .vec   (pending & mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // int_ack only matters in REQ and int_done only in SERVICE; in REQ the
    // ack branch is the only exit, so a simultaneous int_done is ignored.
    always_comb begin
        state_next = state;
        clear      = '0;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    clear[int_id] = 1'b1;
                    state_next    = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.int_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new edge on the source being acknowledged wins over the clear.
        pending_next = (pending & ~clear) | rise;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: only control/state registers exist here and all of them are
        // reset; prev resets high so lines already high raise no edge.
        if (reset) begin
            prev    <= '1;
            pending <= '0;
            mask    <= '1;
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            prev    <= bus.irq_src;
            pending <= pending_next;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
            state   <= state_next;
            // Registered Moore output: high exactly while in REQ.
            int_req <= (state_next == REQ);
            // Latched only on REQ entry; held through SERVICE.
            if (state == IDLE && enc_valid) begin
                int_id <= enc_idx;
            end
        end
    end

    assign bus.int_req = int_req;
    assign bus.int_id  = int_id;
    assign bus.pending = pending;
    assign bus.mask    = mask;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_irq_controller;

    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    irq_controller_if #(.NUM_SOURCES(N), .ID_W(IW)) bus ();

    irq_controller #(.NUM_SOURCES(N), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase 0 = idle, 1 = waiting for ack, 2 = in service.
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pending;
    logic [N-1:0] m_mask;
    int           m_phase;
    int           m_id;
    bit           m_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_tick();
        logic [N-1:0] p;
        logic [N-1:0] cand;
        int           next_phase;
        bit           found;
        if (reset) begin
            m_prev    = '1;
            m_pending = '0;
            m_mask    = '1;
            m_phase   = 0;
            m_id      = 0;
            m_req     = 0;
        end else begin
            p          = m_pending;
            next_phase = m_phase;
            if (m_phase == 1) begin
                if (bus.int_ack) begin
                    p[m_id]    = 1'b0;
                    next_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (bus.int_done) next_phase = 0;
            end else begin
                cand  = m_pending & m_mask;
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && cand[i]) begin
                        m_id  = i;
                        found = 1;
                    end
                end
                if (found) next_phase = 1;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.irq_src[i] && !m_prev[i]) p[i] = 1'b1;
            end
            m_prev = bus.irq_src;
            if (bus.mask_we) m_mask = bus.mask_wdata;
            m_pending = p;
            m_phase   = next_phase;
            m_req     = (next_phase == 1);
        end
    endtask

    // One clock: advance the model on the edge, compare shortly after it.
    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        check("int_req", 32'(bus.int_req), 32'(m_req));
        check("int_id",  32'(bus.int_id),  32'(m_id));
        check("pending", 32'(bus.pending), 32'(m_pending));
        check("mask",    32'(bus.mask),    32'(m_mask));
    endtask

    task automatic service_current();
        bus.int_ack = 1'b1;
        cycle();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        cycle();
        bus.int_done = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.irq_src    = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.int_ack    = 1'b0;
        bus.int_done   = 1'b0;
        cycle();
        cycle();
        check("reset_mask", 32'(bus.mask), 32'hF);
        check("reset_req",  32'(bus.int_req), 32'h0);
        reset = 1'b0;
        cycle();

        // Single source, full handshake.
        bus.irq_src = 4'b0001;
        cycle();
        check("s1_pending", 32'(bus.pending), 32'h1);
        check("s1_req_lat", 32'(bus.int_req), 32'h0);
        cycle();
        check("s1_req", 32'(bus.int_req), 32'h1);
        check("s1_id",  32'(bus.int_id),  32'h0);
        bus.int_ack = 1'b1;
        cycle();
        check("s1_ack_pending", 32'(bus.pending), 32'h0);
        check("s1_ack_req",     32'(bus.int_req), 32'h0);
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        cycle();
        bus.int_done = 1'b0;
        bus.irq_src  = '0;
        cycle();

        // Two sources together: lowest first, then back-to-back.
        bus.irq_src = 4'b1010;
        cycle();
        cycle();
        check("s2_first_id", 32'(bus.int_id), 32'h1);
        bus.int_ack = 1'b1;
        cycle();
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        cycle();
        check("s2_gap_req", 32'(bus.int_req), 32'h0);
        bus.int_done = 1'b0;
        cycle();
        check("s2_second_req", 32'(bus.int_req), 32'h1);
        check("s2_second_id",  32'(bus.int_id),  32'h3);
        service_current();
        bus.irq_src = '0;
        cycle();

        // Masked source stays pending until enabled.
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b1110;
        cycle();
        bus.mask_we = 1'b0;
        bus.irq_src = 4'b0001;
        cycle();
        cycle();
        cycle();
        check("s3_masked_req",     32'(bus.int_req), 32'h0);
        check("s3_masked_pending", 32'(bus.pending), 32'h1);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b1111;
        cycle();
        bus.mask_we = 1'b0;
        cycle();
        check("s3_unmask_req", 32'(bus.int_req), 32'h1);
        check("s3_unmask_id",  32'(bus.int_id),  32'h0);
        service_current();
        bus.irq_src = '0;
        cycle();

        // New edge on src2 in the same cycle as its ack: set wins.
        bus.irq_src = 4'b0100;
        cycle();
        cycle();
        bus.irq_src = '0;
        cycle();
        bus.irq_src = 4'b0100;
        bus.int_ack = 1'b1;
        cycle();
        check("s4_set_wins", 32'(bus.pending[2]), 32'h1);
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b1;
        cycle();
        bus.int_done = 1'b0;
        cycle();
        check("s4_rereq",    32'(bus.int_req), 32'h1);
        check("s4_rereq_id", 32'(bus.int_id),  32'h2);
        service_current();
        bus.irq_src = '0;
        cycle();

        // Line held across reset, then reset during SERVICE.
        reset       = 1'b1;
        bus.irq_src = 4'b0010;
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        check("s5_no_pending", 32'(bus.pending), 32'h0);
        bus.irq_src = 4'b0011;
        cycle();
        cycle();
        bus.int_ack = 1'b1;
        cycle();
        bus.int_ack    = 1'b0;
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 4'b0000;
        cycle();
        bus.mask_we = 1'b0;
        reset       = 1'b1;
        cycle();
        check("s5_rst_req",  32'(bus.int_req), 32'h0);
        check("s5_rst_mask", 32'(bus.mask),    32'hF);
        reset = 1'b0;
        cycle();
        check("s5_post_req", 32'(bus.int_req), 32'h0);
        bus.irq_src = '0;
        cycle();

        // Stray ack in IDLE, stray done in REQ.
        bus.int_ack = 1'b1;
        cycle();
        bus.int_ack = 1'b0;
        check("s6_idle_ack", 32'(bus.int_req), 32'h0);
        bus.irq_src = 4'b1000;
        cycle();
        cycle();
        bus.int_done = 1'b1;
        cycle();
        check("s6_req_done", 32'(bus.int_req), 32'h1);
        bus.int_done = 1'b0;
        bus.int_ack  = 1'b1;
        bus.int_done = 1'b1;
        cycle();
        check("s6_ack_and_done", 32'(bus.int_req), 32'h0);
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bus.irq_src[i] = ~bus.irq_src[i];
            end
            bus.mask_we    = ($urandom_range(0, 15) == 0);
            bus.mask_wdata = N'($urandom);
            bus.int_ack    = ($urandom_range(0, 3) == 0);
            bus.int_done   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
